flit_inject: RTL and testbench
==============================

Name: flit_inject

Overview:
- Injection stage placed upstream of the two-port deflection arbiter.
- Accepts local 9-bit flits (destination + payload) from the node through a valid/ready handshake and buffers them in a small FIFO.
- Each cycle it observes the two incoming link flits and writes the head local flit into the first idle slot.
- Drives a registered two-slot flit pair to the arbiter inputs. Adds the 10th (golden) bit when local traffic is starving.

Parameters:
- FIFO_DEPTH, 4, local flit buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, blocked cycles before the next injected flit is marked golden
- IDLE_FLIT, 10'h1C0, idle slot code: bit9=0, dest[8:6]=3'b111, payload 0

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- link1  in  10  incoming flit, slot 1
- link2  in  10  incoming flit, slot 2
- loc_valid  in  1  local flit offered
- loc_data  in  9  local flit: [8:6] dest, [5:0] payload
- loc_ready  out  1  FIFO can accept
- out1  out  10  registered flit to arbiter input 1
- out2  out  10  registered flit to arbiter input 2
- starved  out  1  starve counter at limit
- drop_err  out  1  one-cycle pulse: local flit with dest 3'b111 discarded

Behaviour:
- Reset (async, rst_n=0): out1=out2=IDLE_FLIT; FIFO empty; loc_ready=1; starve count 0; starved=0; drop_err=0.
- Idle detection: a slot is idle when its [8:6]==3'b111 and bit9==0. Only the exact IDLE_FLIT value is ever generated.
- Push: occurs when loc_valid && loc_ready at the clock edge.
  - loc_ready = !full, from registered FIFO state only. It has no combinational dependence on the link inputs.
  - If loc_data[8:6]==3'b111, the flit is accepted, not stored, and drop_err pulses the next cycle.
- Pop / inject: decided each cycle from FIFO head (pre-edge state) and link1/link2.
  - FIFO non-empty and link1 idle: out1 <= {g, head}, out2 <= link2, pop.
  - Else FIFO non-empty and link2 idle: out1 <= link1, out2 <= {g, head}, pop.
  - Else (FIFO empty, or no slot idle): out1 <= link1, out2 <= link2, no pop.
  - Slot 1 has priority when both slots are idle; only one flit is injected per cycle.
  - g = 1 if starved at the decision edge, else 0.
- Latency: link to out is 1 cycle. A local flit reaches out at the earliest 2 cycles after the push edge. An empty FIFO has no bypass.
- Simultaneous push and pop: allowed whenever not full; occupancy is unchanged. A push while full is impossible because loc_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no injection occurs.
  - Saturates at STARVE_LIMIT; starved = (count==STARVE_LIMIT).
  - Clears to 0 on any injection or when the FIFO is empty.
- Link flits are never modified. The golden bit is set only on locally injected flits.
- Reset mid-operation discards FIFO contents and in-flight outputs immediately. No flit is replayed.

Test Plan:
- Reset release, links=IDLE_FLIT, no local traffic -> out1=out2=10'h1C0, loc_ready=1, starved=0 for 10 cycles.
- Push loc_data=9'h045 at cycle 0, links idle -> out1=10'h045, out2=10'h1C0 at cycle 2. FIFO empty afterwards.
- link1=10'h0A3 (busy), link2 idle, push 9'h12F -> out1=10'h0A3, out2=10'h12F. Both slots idle with two queued flits 9'h001, 9'h002 -> injected on consecutive cycles, both in out1.
- Push 5 flits back-to-back while both links are busy -> loc_ready falls after the 4th accept and the 5th is held. Releasing link2 idle drains one per cycle in FIFO order, and loc_ready rises one cycle after the first pop.
- Both links busy for 8 cycles with FIFO holding 9'h0C7 -> starved=1 after the 8th blocked cycle. Then link1 idle -> out1=10'h2C7 (golden set), starved=0 the following cycle.
- Push loc_data=9'h1FF -> drop_err pulses for one cycle, FIFO occupancy unchanged, no injection. Assert rst_n=0 with 3 flits queued -> outputs return to IDLE_FLIT immediately and FIFO is empty.

Source files
------------

// File: rtl/flit_inject.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flit_inject : buffers local flits and injects them into idle link slots   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+

module flit_inject #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         STARVE_LIMIT = 8,
  parameter logic [9:0] IDLE_FLIT    = 10'h1C0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] link1,
  input  logic [9:0] link2,
  input  logic       loc_valid,
  input  logic [8:0] loc_data,
  output logic       loc_ready,
  output logic [9:0] out1,
  output logic [9:0] out2,
  output logic       starved,
  output logic       drop_err
);

  localparam int            AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW         = $clog2(FIFO_DEPTH) + 1;
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]    IDLE_DEST  = 3'b111;

  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [9:0]    out1_q, out1_d;
  logic [9:0]    out2_q, out2_d;
  logic          drop_q, drop_d;

  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       drop;
  logic       store;
  logic       link1_idle;
  logic       link2_idle;
  logic       inj1;
  logic       inj2;
  logic       pop;
  logic       golden;
  logic [8:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign loc_ready  = !fifo_full;

  // Flits addressed to the idle destination would be indistinguishable from
  // an empty slot downstream, so they are swallowed instead of stored.
  assign push  = loc_valid && !fifo_full;
  assign drop  = push && (loc_data[8:6] == IDLE_DEST);
  assign store = push && !drop;

  assign link1_idle = !link1[9] && (link1[8:6] == IDLE_DEST);
  assign link2_idle = !link2[9] && (link2[8:6] == IDLE_DEST);

  assign head   = mem_q[rd_ptr_q];
  assign inj1   = !fifo_empty && link1_idle;
  assign inj2   = !fifo_empty && !link1_idle && link2_idle;
  assign pop    = inj1 || inj2;
  assign golden = (starve_q == STARVE_MAX);

  always_comb begin
    out1_d = link1;
    out2_d = link2;
    if (inj1) begin
      out1_d = {golden, head};
    end else if (inj2) begin
      out2_d = {golden, head};
    end

    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (store && (wr_ptr_q == AW'(i))) begin
        mem_d[i] = loc_data;
      end
    end

    wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({store, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Counts only cycles where a queued flit was actually blocked.
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    drop_d = drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      out1_q   <= IDLE_FLIT;
      out2_q   <= IDLE_FLIT;
      drop_q   <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
      drop_q   <= drop_d;
    end
  end

  assign out1     = out1_q;
  assign out2     = out2_q;
  assign starved  = (starve_q == STARVE_MAX);
  assign drop_err = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_flit_inject.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flit_inject : directed self-checking bench for flit_inject             |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+

module tb_flit_inject;

  localparam logic [9:0] IDLE  = 10'h1C0;
  localparam logic [9:0] BUSY1 = 10'h0A3;
  localparam logic [9:0] BUSY2 = 10'h0B5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] link1 = IDLE;
  logic [9:0] link2 = IDLE;
  logic       loc_valid = 1'b0;
  logic [8:0] loc_data = '0;
  logic       loc_ready;
  logic [9:0] out1;
  logic [9:0] out2;
  logic       starved;
  logic       drop_err;

  int errors = 0;
  int checks = 0;

  flit_inject #(
    .FIFO_DEPTH  (4),
    .STARVE_LIMIT(8),
    .IDLE_FLIT   (10'h1C0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .link1    (link1),
    .link2    (link2),
    .loc_valid(loc_valid),
    .loc_data (loc_data),
    .loc_ready(loc_ready),
    .out1     (out1),
    .out2     (out2),
    .starved  (starved),
    .drop_err (drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    link1 = IDLE; link2 = IDLE; loc_valid = 1'b0; rst_n = 1'b0;
    tick(); tick();
    checks++; if (out1 !== IDLE) begin errors++; $display("FAIL reset_out1 got=%h exp=%h", out1, IDLE); end
    checks++; if (out2 !== IDLE) begin errors++; $display("FAIL reset_out2 got=%h exp=%h", out2, IDLE); end
    checks++; if (loc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", loc_ready); end
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL reset_starved got=%b exp=0", starved); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_err); end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (out1 !== IDLE || out2 !== IDLE) begin errors++; $display("FAIL idle_outs cyc%0d got=%h/%h exp=%h/%h", c, out1, out2, IDLE, IDLE); end
      checks++; if (loc_ready !== 1'b1 || starved !== 1'b0) begin errors++; $display("FAIL idle_flags cyc%0d got ready=%b starved=%b exp 1/0", c, loc_ready, starved); end
    end
  endtask

  task automatic test_single();
    loc_valid = 1'b1; loc_data = 9'h045;
    tick();
    loc_valid = 1'b0;
    checks++; if (out1 !== IDLE) begin errors++; $display("FAIL single_no_bypass got=%h exp=%h", out1, IDLE); end
    tick();
    checks++; if (out1 !== 10'h045) begin errors++; $display("FAIL single_out1 got=%h exp=%h", out1, 10'h045); end
    checks++; if (out2 !== IDLE) begin errors++; $display("FAIL single_out2 got=%h exp=%h", out2, IDLE); end
    tick();
    checks++; if (out1 !== IDLE) begin errors++; $display("FAIL single_empty_after got=%h exp=%h", out1, IDLE); end
  endtask

  task automatic test_slot2();
    link1 = BUSY1; link2 = IDLE; loc_valid = 1'b1; loc_data = 9'h12F;
    tick();
    loc_valid = 1'b0;
    checks++; if (out1 !== BUSY1 || out2 !== IDLE) begin errors++; $display("FAIL slot2_pass got=%h/%h exp=%h/%h", out1, out2, BUSY1, IDLE); end
    tick();
    checks++; if (out1 !== BUSY1 || out2 !== 10'h12F) begin errors++; $display("FAIL slot2_inject got=%h/%h exp=%h/%h", out1, out2, BUSY1, 10'h12F); end
    // A golden flit to dest 7 is traffic, not an idle slot.
    link1 = 10'h3C5; loc_valid = 1'b1; loc_data = 9'h015;
    tick();
    loc_valid = 1'b0;
    tick();
    checks++; if (out1 !== 10'h3C5 || out2 !== 10'h015) begin errors++; $display("FAIL golden_link_busy got=%h/%h exp=%h/%h", out1, out2, 10'h3C5, 10'h015); end
    link1 = BUSY1; link2 = BUSY2;
    loc_valid = 1'b1; loc_data = 9'h001;
    tick();
    loc_data = 9'h002;
    tick();
    loc_valid = 1'b0; link1 = IDLE; link2 = IDLE;
    tick();
    checks++; if (out1 !== 10'h001 || out2 !== IDLE) begin errors++; $display("FAIL both_idle_first got=%h/%h exp=%h/%h", out1, out2, 10'h001, IDLE); end
    tick();
    checks++; if (out1 !== 10'h002 || out2 !== IDLE) begin errors++; $display("FAIL both_idle_second got=%h/%h exp=%h/%h", out1, out2, 10'h002, IDLE); end
    tick();
    checks++; if (out1 !== IDLE) begin errors++; $display("FAIL both_idle_drained got=%h exp=%h", out1, IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_q [5];
    exp_q = '{10'h010, 10'h011, 10'h012, 10'h013, 10'h014};
    link1 = BUSY1; link2 = BUSY2; loc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      loc_data = 9'(10'h010 + k);
      tick();
      if (k == 2) begin
        checks++; if (loc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_3 got=%b exp=1", loc_ready); end
      end
    end
    checks++; if (loc_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_4 got=%b exp=0", loc_ready); end
    loc_data = 9'h014;
    tick();
    checks++; if (loc_ready !== 1'b0) begin errors++; $display("FAIL b2b_held_5 got=%b exp=0", loc_ready); end
    checks++; if (out1 !== BUSY1 || out2 !== BUSY2) begin errors++; $display("FAIL b2b_links got=%h/%h exp=%h/%h", out1, out2, BUSY1, BUSY2); end
    link2 = IDLE;
    tick();
    checks++; if (loc_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise got=%b exp=1", loc_ready); end
    checks++; if (out2 !== exp_q[0] || out1 !== BUSY1) begin errors++; $display("FAIL b2b_drain0 got=%h/%h exp=%h/%h", out1, out2, BUSY1, exp_q[0]); end
    tick();
    loc_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (k > 1) tick();
      checks++; if (out2 !== exp_q[k]) begin errors++; $display("FAIL b2b_drain%0d got=%h exp=%h", k, out2, exp_q[k]); end
    end
    tick();
    checks++; if (out2 !== IDLE) begin errors++; $display("FAIL b2b_empty got=%h exp=%h", out2, IDLE); end
  endtask

  task automatic test_starve();
    link1 = BUSY1; link2 = BUSY2; loc_valid = 1'b1; loc_data = 9'h0C7;
    tick();
    loc_valid = 1'b0;
    repeat (7) tick();
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_7 got=%b exp=0", starved); end
    tick();
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_8 got=%b exp=1", starved); end
    tick();
    checks++; if (starved !== 1'b1) begin errors++; $display("FAIL starve_sat got=%b exp=1", starved); end
    link1 = IDLE;
    tick();
    checks++; if (out1 !== 10'h2C7 || out2 !== BUSY2) begin errors++; $display("FAIL starve_golden got=%h/%h exp=%h/%h", out1, out2, 10'h2C7, BUSY2); end
    checks++; if (starved !== 1'b0) begin errors++; $display("FAIL starve_clear got=%b exp=0", starved); end
    link2 = IDLE;
    tick();
  endtask

  task automatic test_drop();
    link1 = IDLE; link2 = IDLE; loc_valid = 1'b1; loc_data = 9'h1FF;
    tick();
    loc_valid = 1'b0;
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_pulse got=%b exp=1", drop_err); end
    checks++; if (out1 !== IDLE) begin errors++; $display("FAIL drop_out_a got=%h exp=%h", out1, IDLE); end
    tick();
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL drop_one_cycle got=%b exp=0", drop_err); end
    checks++; if (out1 !== IDLE || out2 !== IDLE) begin errors++; $display("FAIL drop_no_inject got=%h/%h exp=%h/%h", out1, out2, IDLE, IDLE); end
    loc_valid = 1'b1; loc_data = 9'h0AA;
    tick();
    loc_valid = 1'b0;
    tick();
    checks++; if (out1 !== 10'h0AA) begin errors++; $display("FAIL drop_fifo_intact got=%h exp=%h", out1, 10'h0AA); end
  endtask

  task automatic test_reset_mid();
    link1 = BUSY1; link2 = BUSY2; loc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      loc_data = 9'(10'h031 + k);
      tick();
    end
    loc_valid = 1'b0;
    checks++; if (out1 !== BUSY1) begin errors++; $display("FAIL rmid_pre got=%h exp=%h", out1, BUSY1); end
    rst_n = 1'b0;
    #1;
    checks++; if (out1 !== IDLE || out2 !== IDLE) begin errors++; $display("FAIL rmid_outs got=%h/%h exp=%h/%h", out1, out2, IDLE, IDLE); end
    checks++; if (loc_ready !== 1'b1 || starved !== 1'b0) begin errors++; $display("FAIL rmid_flags got ready=%b starved=%b exp 1/0", loc_ready, starved); end
    tick();
    rst_n = 1'b1; link1 = IDLE; link2 = IDLE;
    tick(); tick();
    checks++; if (out1 !== IDLE || out2 !== IDLE) begin errors++; $display("FAIL rmid_no_replay got=%h/%h exp=%h/%h", out1, out2, IDLE, IDLE); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_slot2();
    test_back_to_back();
    test_starve();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
